// File: rtl/sprite_pkg.sv
// Shared constants for the sprite pixel engine: colour/screen widths, the
// transparent key, action encodings and the default one-shot action set.
package sprite_pkg;

  localparam int RGB_W = 12;
  localparam int SCR_W = 10;

  localparam logic [RGB_W-1:0] TRANSP_DEF       = 12'hFFF;
  localparam logic [3:0]       ONESHOT_MASK_DEF = 4'b0100;

  typedef enum logic [1:0] {
    ACT_IDLE = 2'd0,
    ACT_RUN  = 2'd1,
    ACT_JUMP = 2'd2,
    ACT_FALL = 2'd3
  } action_e;

  // Index width that stays at least one bit for single-entry ranges.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sprite_frame_ctr.sv
// Animation frame sequencer: latches the current action, divides frame_tick
// by FRAME_DIV and advances the frame, looping or saturating per action.
module sprite_frame_ctr
  import sprite_pkg::*;
#(
  parameter int                   N_ACTIONS    = 4,
  parameter int                   N_FRAMES     = 4,
  parameter int                   FRAME_DIV    = 1,
  parameter logic [N_ACTIONS-1:0] ONESHOT_MASK = N_ACTIONS'(ONESHOT_MASK_DEF),
  localparam int                  ACT_W        = clog2_min1(N_ACTIONS),
  localparam int                  FR_W         = clog2_min1(N_FRAMES),
  localparam int                  DIV_W        = clog2_min1(FRAME_DIV)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_tick,
  input  logic [ACT_W-1:0] action,
  output logic [ACT_W-1:0] action_q,
  output logic [FR_W-1:0]  frame_idx
);

  localparam logic [FR_W-1:0]  FR_LAST  = FR_W'(N_FRAMES - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FRAME_DIV - 1);

  logic [ACT_W-1:0] action_r, action_s;
  logic [FR_W-1:0]  frame_r, frame_s;
  logic [DIV_W-1:0] div_r, div_s;

  // Next-state: an action change restarts the strip and swallows any coincident tick.
  always_comb begin
    action_s = action_r;
    frame_s  = frame_r;
    div_s    = div_r;
    if (action != action_r) begin
      action_s = action;
      frame_s  = '0;
      div_s    = '0;
    end else if (frame_tick) begin
      if (div_r == DIV_LAST) begin
        div_s = '0;
        if (frame_r == FR_LAST) begin
          frame_s = ONESHOT_MASK[action_r] ? FR_LAST : '0;
        end else begin
          frame_s = frame_r + FR_W'(1);
        end
      end else begin
        div_s = div_r + DIV_W'(1);
      end
    end else begin
      div_s = div_r;
    end
  end

  // Counter and action registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      action_r <= '0;
      frame_r  <= '0;
      div_r    <= '0;
    end else begin
      action_r <= action_s;
      frame_r  <= frame_s;
      div_r    <= div_s;
    end
  end

  assign action_q  = action_r;
  assign frame_idx = frame_r;

endmodule

// File: rtl/sprite_animator.sv
// Pipelined sprite pixel engine: box test, mirrored ROM addressing, a delay
// line matched to ROM latency and colour-keyed output. Latency col/row to
// spr_rgb/is_spr is ROM_LAT+2 cycles.
// Optional build macro SPRITE_BLINK_EN adds a blink input that gates is_spr
// on alternate frame_tick phases.
module sprite_animator
  import sprite_pkg::*;
#(
  parameter int                   SPR_W        = 31,
  parameter int                   SPR_H        = 23,
  parameter int                   N_ACTIONS    = 4,
  parameter int                   N_FRAMES     = 4,
  parameter int                   FRAME_DIV    = 1,
  parameter logic [N_ACTIONS-1:0] ONESHOT_MASK = N_ACTIONS'(ONESHOT_MASK_DEF),
  parameter int                   ROM_LAT      = 1,
  parameter logic [RGB_W-1:0]     TRANSP       = TRANSP_DEF,
  localparam int                  ACT_W        = clog2_min1(N_ACTIONS),
  localparam int                  FR_W         = clog2_min1(N_FRAMES),
  localparam int                  ADDR_W       = $clog2(N_ACTIONS * N_FRAMES * SPR_W * SPR_H)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_tick,
  input  logic [SCR_W-1:0]  col,
  input  logic [SCR_W-1:0]  row,
  input  logic [SCR_W-1:0]  pos_x,
  input  logic [SCR_W-1:0]  pos_y,
  input  logic              dir,
  input  logic [ACT_W-1:0]  action,
`ifdef SPRITE_BLINK_EN
  input  logic              blink,
`endif
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [RGB_W-1:0]  rom_data,
  output logic [RGB_W-1:0]  spr_rgb,
  output logic              is_spr,
  output logic [SCR_W-1:0]  ctr_x,
  output logic [SCR_W-1:0]  ctr_y,
  output logic [FR_W-1:0]   frame_idx
);

  localparam logic [SCR_W-1:0] SPR_W_S = SCR_W'(SPR_W);
  localparam logic [SCR_W-1:0] SPR_H_S = SCR_W'(SPR_H);

  logic [ACT_W-1:0]  action_q_s;
  logic [FR_W-1:0]   frame_s;
  logic [SCR_W-1:0]  dx_s, dy_s, mx_s;
  logic              in_box_s;
  logic [ADDR_W-1:0] addr_s;
  logic [ADDR_W-1:0] rom_addr_r;
  logic [ROM_LAT:0]  box_pipe_r;
  logic              opaque_s;
  logic [RGB_W-1:0]  spr_rgb_r;
  logic              is_spr_r;

  sprite_frame_ctr #(
    .N_ACTIONS   (N_ACTIONS),
    .N_FRAMES    (N_FRAMES),
    .FRAME_DIV   (FRAME_DIV),
    .ONESHOT_MASK(ONESHOT_MASK)
  ) u_frame_ctr (
    .clk       (clk),
    .rst       (rst),
    .frame_tick(frame_tick),
    .action    (action),
    .action_q  (action_q_s),
    .frame_idx (frame_s)
  );

  // Box test and linear ROM address; unsigned wrap rejects pixels left of / above the sprite.
  always_comb begin
    dx_s     = col - pos_x;
    dy_s     = row - pos_y;
    in_box_s = (dx_s < SPR_W_S) && (dy_s < SPR_H_S);
    mx_s     = dir ? dx_s : (SPR_W_S - SCR_W'(1) - dx_s);
    addr_s   = ((ADDR_W'(action_q_s) * ADDR_W'(N_FRAMES) + ADDR_W'(frame_s))
                * ADDR_W'(SPR_H) + ADDR_W'(dy_s)) * ADDR_W'(SPR_W) + ADDR_W'(mx_s);
  end

`ifdef SPRITE_BLINK_EN
  logic phase_r;

  // Blink phase flips on each animation strobe while blinking, parks at 0 otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_r <= 1'b0;
    end else if (!blink) begin
      phase_r <= 1'b0;
    end else if (frame_tick) begin
      phase_r <= ~phase_r;
    end else begin
      phase_r <= phase_r;
    end
  end

  // Opaque pixel qualifier, suppressed in the hidden blink phase.
  always_comb begin
    opaque_s = (rom_data != TRANSP) && !phase_r;
  end
`else
  // Opaque pixel qualifier.
  always_comb begin
    opaque_s = (rom_data != TRANSP);
  end
`endif

  // Address register and in-box delay line aligned with ROM read data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rom_addr_r <= '0;
      box_pipe_r <= '0;
    end else begin
      rom_addr_r <= in_box_s ? addr_s : '0;
      box_pipe_r <= {box_pipe_r[ROM_LAT-1:0], in_box_s};
    end
  end

  // Output register with colour-key test.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      spr_rgb_r <= TRANSP;
      is_spr_r  <= 1'b0;
    end else begin
      spr_rgb_r <= box_pipe_r[ROM_LAT] ? rom_data : TRANSP;
      is_spr_r  <= box_pipe_r[ROM_LAT] && opaque_s;
    end
  end

  assign rom_addr  = rom_addr_r;
  assign spr_rgb   = spr_rgb_r;
  assign is_spr    = is_spr_r;
  assign frame_idx = frame_s;
  assign ctr_x     = pos_x + SCR_W'(SPR_W / 2);
  assign ctr_y     = pos_y + SCR_W'(SPR_H / 2);

endmodule

// File: tb/tb_sprite_animator.sv
// Directed self-checking bench for sprite_animator (FRAME_DIV=2, ROM_LAT=1).
module tb_sprite_animator;
  import sprite_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        frame_tick = 1'b0;
  logic [9:0]  col = 10'd0, row = 10'd0, pos_x = 10'd100, pos_y = 10'd50;
  logic        dir = 1'b1;
  logic [1:0]  action = 2'd0;
  logic        blink = 1'b0;
  logic [13:0] rom_addr;
  logic [11:0] rom_data;
  logic [11:0] spr_rgb;
  logic        is_spr;
  logic [9:0]  ctr_x, ctr_y;
  logic [1:0]  frame_idx;

  int n_tests = 0;
  int n_fail  = 0;

  sprite_animator #(.FRAME_DIV(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .frame_tick(frame_tick),
    .col       (col),
    .row       (row),
    .pos_x     (pos_x),
    .pos_y     (pos_y),
    .dir       (dir),
    .action    (action),
`ifdef SPRITE_BLINK_EN
    .blink     (blink),
`endif
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .spr_rgb   (spr_rgb),
    .is_spr    (is_spr),
    .ctr_x     (ctr_x),
    .ctr_y     (ctr_y),
    .frame_idx (frame_idx)
  );

  always #5 clk = ~clk;

  // ROM model: every 7th address (mod 7 == 3) holds the transparent key.
  function automatic logic [11:0] rom_val(input logic [13:0] a);
    if ((a % 14'd7) == 14'd3) return 12'hFFF;
    else return 12'(a + 14'h100);
  endfunction

  always @(posedge clk) rom_data <= rom_val(rom_addr);

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_tick();
    frame_tick = 1'b1;
    step(1);
    frame_tick = 1'b0;
  endtask

  task automatic test_reset();
    col = 10'd0; row = 10'd0;
    step(2);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      n_tests++;
      if (rom_addr !== 14'd0) begin n_fail++; $display("FAIL reset_idle_addr got %0d exp 0", rom_addr); end
    end
    col = 10'd100; row = 10'd50;
    for (int i = 0; i < 4; i++) pulse_tick();
    step(3);
    n_tests++;
    if (frame_idx !== 2'd2) begin n_fail++; $display("FAIL pre_reset_frame got %0d exp 2", frame_idx); end
    n_tests++;
    if (spr_rgb !== 12'h692) begin n_fail++; $display("FAIL pre_reset_rgb got %h exp 692", spr_rgb); end
    #2 rst = 1'b0;
    #1;
    n_tests++;
    if (frame_idx !== 2'd0 || is_spr !== 1'b0 || spr_rgb !== 12'hFFF || rom_addr !== 14'd0) begin
      n_fail++; $display("FAIL reset_async got frame=%0d is=%b rgb=%h addr=%0d exp 0/0/fff/0", frame_idx, is_spr, spr_rgb, rom_addr);
    end
    col = 10'd0; row = 10'd0;
    step(1);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      n_tests++;
      if (rom_addr !== 14'd0 || is_spr !== 1'b0) begin
        n_fail++; $display("FAIL reset_release got addr=%0d is=%b exp 0/0", rom_addr, is_spr);
      end
    end
  endtask

  task automatic test_address();
    logic [9:0]  t_col [9] = '{10'd100, 10'd130, 10'd103, 10'd100, 10'd99, 10'd131, 10'd100, 10'd100, 10'd130};
    logic [9:0]  t_row [9] = '{10'd50,  10'd72,  10'd50,  10'd50,  10'd50, 10'd50,  10'd49,  10'd73,  10'd72};
    logic        t_dir [9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [13:0] t_addr[9] = '{14'd0, 14'd712, 14'd3, 14'd30, 14'd0, 14'd0, 14'd0, 14'd0, 14'd682};
    logic [11:0] t_rgb [9] = '{12'h100, 12'h3C8, 12'hFFF, 12'h11E, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF};
    logic        t_is  [9] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    n_tests++;
    if (ctr_x !== 10'd115 || ctr_y !== 10'd61) begin
      n_fail++; $display("FAIL centre got (%0d,%0d) exp (115,61)", ctr_x, ctr_y);
    end
    for (int i = 0; i < 9; i++) begin
      col = 10'd0; row = 10'd0; dir = t_dir[i];
      step(4);
      col = t_col[i]; row = t_row[i];
      step(1);
      n_tests++;
      if (rom_addr !== t_addr[i]) begin n_fail++; $display("FAIL addr[%0d] got %0d exp %0d", i, rom_addr, t_addr[i]); end
      step(1);
      n_tests++;
      if (is_spr !== 1'b0 || spr_rgb !== 12'hFFF) begin
        n_fail++; $display("FAIL early_out[%0d] got is=%b rgb=%h exp 0/fff", i, is_spr, spr_rgb);
      end
      step(1);
      n_tests++;
      if (is_spr !== t_is[i] || spr_rgb !== t_rgb[i]) begin
        n_fail++; $display("FAIL pixel[%0d] got is=%b rgb=%h exp %b/%h", i, is_spr, spr_rgb, t_is[i], t_rgb[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] exp_rgb;
    dir = 1'b1; row = 10'd50;
    for (int i = 0; i < 7; i++) begin
      col = 10'(100 + i);
      step(1);
      n_tests++;
      if (rom_addr !== 14'(i)) begin n_fail++; $display("FAIL b2b_addr[%0d] got %0d exp %0d", i, rom_addr, i); end
      if (i >= 2) begin
        exp_rgb = rom_val(14'(i - 2));
        n_tests++;
        if (spr_rgb !== exp_rgb || is_spr !== (exp_rgb != 12'hFFF)) begin
          n_fail++; $display("FAIL b2b_out[%0d] got %h/%b exp %h", i, spr_rgb, is_spr, exp_rgb);
        end
      end
    end
    col = 10'd0; row = 10'd0;
  endtask

  task automatic test_frame_loop();
    logic [1:0] exp_f;
    action = ACT_RUN;
    step(1);
    n_tests++;
    if (frame_idx !== 2'd0) begin n_fail++; $display("FAIL loop_start got %0d exp 0", frame_idx); end
    for (int k = 1; k <= 8; k++) begin
      pulse_tick();
      exp_f = 2'((k / 2) % 4);
      n_tests++;
      if (frame_idx !== exp_f) begin n_fail++; $display("FAIL loop_tick[%0d] got %0d exp %0d", k, frame_idx, exp_f); end
    end
  endtask

  task automatic test_oneshot();
    logic [1:0] exp_f;
    action = ACT_JUMP;
    step(1);
    for (int k = 1; k <= 20; k++) begin
      pulse_tick();
      exp_f = (k / 2 > 3) ? 2'd3 : 2'(k / 2);
      n_tests++;
      if (frame_idx !== exp_f) begin n_fail++; $display("FAIL oneshot_tick[%0d] got %0d exp %0d", k, frame_idx, exp_f); end
    end
  endtask

  task automatic test_action_tick();
    action = ACT_RUN;
    frame_tick = 1'b1;
    step(1);
    frame_tick = 1'b0;
    n_tests++;
    if (frame_idx !== 2'd0) begin n_fail++; $display("FAIL act_change got %0d exp 0", frame_idx); end
    pulse_tick();
    n_tests++;
    if (frame_idx !== 2'd0) begin n_fail++; $display("FAIL act_tick_discard got %0d exp 0", frame_idx); end
    pulse_tick();
    n_tests++;
    if (frame_idx !== 2'd1) begin n_fail++; $display("FAIL act_tick_next got %0d exp 1", frame_idx); end
  endtask

`ifdef SPRITE_BLINK_EN
  task automatic test_blink();
    logic exp_is;
    action = ACT_IDLE; dir = 1'b1; col = 10'd100; row = 10'd50;
    step(4);
    blink = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      pulse_tick();
      step(3);
      exp_is = (k % 2 == 0);
      n_tests++;
      if (is_spr !== exp_is) begin n_fail++; $display("FAIL blink[%0d] got %b exp %b", k, is_spr, exp_is); end
    end
    pulse_tick();
    blink = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step(3);
      n_tests++;
      if (is_spr !== 1'b1) begin n_fail++; $display("FAIL blink_off[%0d] got %b exp 1", k, is_spr); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_address();
    test_back_to_back();
    test_frame_loop();
    test_oneshot();
    test_action_tick();
`ifdef SPRITE_BLINK_EN
    test_blink();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
